// File: rtl/axi4_sram_slave.sv
// AXI4 slave that turns INCR/FIXED bursts into single-port synchronous SRAM
// accesses. Reads and writes are serialized by a fair arbiter. A 2-entry read
// buffer keeps one R beat per cycle flowing while absorbing R backpressure.
//
// state   | meaning
// IDLE    | arbitrate between AW and AR, accept one request
// WR_DATA | accept W beats, one SRAM write per W handshake
// WR_RESP | present B until the master takes it
// RD_DATA | issue SRAM reads against buffer credits, stream R beats
`timescale 1ns/1ps
module axi4_sram_slave #(
    parameter int IDSIZE = 4,
    parameter int ASIZE  = 8,
    parameter int LSIZE  = 8,
    parameter int DSIZE  = 8
) (
    input  logic              axi_aclk,
    input  logic              axi_areset,
    input  logic [IDSIZE-1:0] axi_awid,
    input  logic [ASIZE-1:0]  axi_awaddr,
    input  logic [LSIZE-1:0]  axi_awlen,
    input  logic [1:0]        axi_awburst,
    input  logic              axi_awvalid,
    output logic              axi_awready,
    input  logic [DSIZE-1:0]  axi_wdata,
    input  logic              axi_wlast,
    input  logic              axi_wvalid,
    output logic              axi_wready,
    output logic [IDSIZE-1:0] axi_bid,
    output logic [1:0]        axi_bresp,
    output logic              axi_bvalid,
    input  logic              axi_bready,
    input  logic [IDSIZE-1:0] axi_arid,
    input  logic [ASIZE-1:0]  axi_araddr,
    input  logic [LSIZE-1:0]  axi_arlen,
    input  logic [1:0]        axi_arburst,
    input  logic              axi_arvalid,
    output logic              axi_arready,
    output logic [IDSIZE-1:0] axi_rid,
    output logic [DSIZE-1:0]  axi_rdata,
    output logic [1:0]        axi_rresp,
    output logic              axi_rlast,
    output logic              axi_rvalid,
    input  logic              axi_rready,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ASIZE-1:0]  sram_addr,
    output logic [DSIZE-1:0]  sram_wdata,
    input  logic [DSIZE-1:0]  sram_rdata
);

    typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

    state_t            state_q;
    logic [IDSIZE-1:0] id_q;
    logic [ASIZE-1:0]  addr_q;
    logic [LSIZE-1:0]  len_q;
    logic [1:0]        burst_q;
    logic [LSIZE:0]    beat_q;       // write beats accepted, or read beats issued
    logic              err_q;
    logic              last_dir_q;   // 1 = last served a write, 0 = read
    logic              infl_q;       // SRAM read data arrives this cycle
    logic              infl_last_q;
    logic [DSIZE-1:0]  fifo_data_q [2];
    logic              fifo_last_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        fifo_cnt_q;

    logic             grant_w, grant_r, aw_hs, ar_hs, w_hs, w_final;
    logic             r_pop, rd_issue, rd_final_issue;
    logic [2:0]       occ_after;
    logic [ASIZE-1:0] addr_next;

    assign grant_w = axi_awvalid && (!axi_arvalid || !last_dir_q);
    assign grant_r = axi_arvalid && (!axi_awvalid || last_dir_q);

    assign axi_awready = (state_q == IDLE) && grant_w;
    assign axi_arready = (state_q == IDLE) && grant_r;
    assign aw_hs       = axi_awvalid && axi_awready;
    assign ar_hs       = axi_arvalid && axi_arready;

    assign axi_wready = (state_q == WR_DATA);
    assign w_hs       = axi_wvalid && axi_wready;
    assign w_final    = (beat_q == {1'b0, len_q});

    assign axi_bvalid = (state_q == WR_RESP);
    assign axi_bid    = id_q;
    assign axi_bresp  = (axi_bvalid && err_q) ? 2'b10 : 2'b00;

    // FIXED holds the address; INCR and WRAP (treated as INCR) step by one word
    assign addr_next = (burst_q == 2'b00) ? addr_q : addr_q + ASIZE'(1);

    assign axi_rvalid = (fifo_cnt_q != 2'd0);
    assign axi_rdata  = fifo_data_q[rd_ptr_q];
    assign axi_rlast  = axi_rvalid && fifo_last_q[rd_ptr_q];
    assign axi_rid    = id_q;
    assign axi_rresp  = 2'b00;
    assign r_pop      = axi_rvalid && axi_rready;

    // A pop in this cycle returns its credit in time for a same-cycle issue
    assign occ_after      = {1'b0, fifo_cnt_q} + {2'b00, infl_q} - {2'b00, r_pop};
    assign rd_issue       = (state_q == RD_DATA) && (beat_q <= {1'b0, len_q}) && (occ_after < 3'd2);
    assign rd_final_issue = rd_issue && (beat_q == {1'b0, len_q});

    assign sram_en    = w_hs || rd_issue;
    assign sram_we    = w_hs;
    assign sram_addr  = addr_q;
    assign sram_wdata = w_hs ? axi_wdata : '0;

    // Transaction FSM: arbitration, burst address/beat tracking, response state
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q     <= IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            burst_q     <= 2'b00;
            beat_q      <= '0;
            err_q       <= 1'b0;
            last_dir_q  <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            infl_q      <= rd_issue;
            infl_last_q <= rd_final_issue;
            case (state_q)
                IDLE: begin
                    if (aw_hs) begin
                        id_q    <= axi_awid;
                        addr_q  <= axi_awaddr;
                        len_q   <= axi_awlen;
                        burst_q <= axi_awburst;
                        beat_q  <= '0;
                        err_q   <= 1'b0;
                        state_q <= WR_DATA;
                    end else if (ar_hs) begin
                        id_q    <= axi_arid;
                        addr_q  <= axi_araddr;
                        len_q   <= axi_arlen;
                        burst_q <= axi_arburst;
                        beat_q  <= '0;
                        state_q <= RD_DATA;
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        addr_q <= addr_next;
                        beat_q <= beat_q + (LSIZE+1)'(1);
                        // Beat count decides the end; wlast is only audited
                        if (axi_wlast != w_final) err_q <= 1'b1;
                        if (w_final) state_q <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axi_bready) begin
                        state_q    <= IDLE;
                        last_dir_q <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (rd_issue) begin
                        addr_q <= addr_next;
                        beat_q <= beat_q + (LSIZE+1)'(1);
                    end
                    if (r_pop && axi_rlast) begin
                        state_q    <= IDLE;
                        last_dir_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Two-entry read buffer: push SRAM data the cycle after issue, pop on R handshake
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (infl_q) begin
                fifo_data_q[wr_ptr_q] <= sram_rdata;
                fifo_last_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (r_pop) rd_ptr_q <= ~rd_ptr_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, infl_q} - {1'b0, r_pop};
        end
    end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave with a behavioural synchronous SRAM.
`timescale 1ns/1ps
module tb_axi4_sram_slave;

    logic       axi_aclk = 1'b0;
    logic       axi_areset = 1'b1;
    logic [3:0] axi_awid = '0, axi_arid = '0, axi_bid, axi_rid;
    logic [7:0] axi_awaddr = '0, axi_araddr = '0, axi_awlen = '0, axi_arlen = '0;
    logic [1:0] axi_awburst = '0, axi_arburst = '0, axi_bresp, axi_rresp;
    logic       axi_awvalid = 0, axi_awready, axi_arvalid = 0, axi_arready;
    logic [7:0] axi_wdata = '0, axi_rdata;
    logic       axi_wlast = 0, axi_wvalid = 0, axi_wready;
    logic       axi_bvalid, axi_bready = 0;
    logic       axi_rlast, axi_rvalid, axi_rready = 0;
    logic       sram_en, sram_we;
    logic [7:0] sram_addr, sram_wdata, sram_rdata;

    logic [7:0] mem [256];
    int checks = 0;
    int errors = 0;

    axi4_sram_slave #(.IDSIZE(4), .ASIZE(8), .LSIZE(8), .DSIZE(8)) dut (
        .axi_aclk(axi_aclk), .axi_areset(axi_areset),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready), .axi_bid(axi_bid), .axi_bresp(axi_bresp),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 axi_aclk = ~axi_aclk;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        sram_rdata = 8'h00;
    end

    always @(posedge axi_aclk) begin
        if (sram_en && sram_we) mem[sram_addr] <= sram_wdata;
        if (sram_en && !sram_we) sram_rdata <= mem[sram_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic aw_phase(input [3:0] id, input [7:0] addr, input [7:0] len, input [1:0] burst);
        int n = 0;
        axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awburst = burst; axi_awvalid = 1;
        #1;
        while (!axi_awready && n < 20) begin @(posedge axi_aclk); #1; n++; end
        chk("aw_grant", n < 20, 1);
        @(posedge axi_aclk); #1;
        axi_awvalid = 0;
    endtask

    task automatic ar_phase(input [3:0] id, input [7:0] addr, input [7:0] len, input [1:0] burst);
        int n = 0;
        axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arburst = burst; axi_arvalid = 1;
        #1;
        while (!axi_arready && n < 20) begin @(posedge axi_aclk); #1; n++; end
        chk("ar_grant", n < 20, 1);
        @(posedge axi_aclk); #1;
        axi_arvalid = 0;
    endtask

    // Starts one step after the AW handshake edge; every beat is offered at once
    task automatic write_data(input [3:0] id, input [7:0] addr, input [7:0] len, input [1:0] burst,
                              input [7:0] d0, input int wlast_idx, input [1:0] exp_resp);
        logic [7:0] ea = addr;
        for (int i = 0; i <= int'(len); i++) begin
            axi_wvalid = 1; axi_wdata = d0 + 8'(i); axi_wlast = (i == wlast_idx);
            @(negedge axi_aclk);
            chk("w_wready", axi_wready, 1);
            chk("w_sram_en", {sram_en, sram_we}, 2'b11);
            chk("w_sram_addr", sram_addr, ea);
            chk("w_sram_wdata", sram_wdata, d0 + 8'(i));
            chk("w_no_bvalid", axi_bvalid, 0);
            if (burst != 2'b00) ea = ea + 8'd1;
            @(posedge axi_aclk); #1;
        end
        axi_wvalid = 0; axi_wlast = 0;
        @(negedge axi_aclk);
        chk("b_valid", axi_bvalid, 1);
        chk("b_id", axi_bid, id);
        chk("b_resp", axi_bresp, exp_resp);
        chk("b_no_sram", sram_en, 0);
        axi_bready = 1;
        @(posedge axi_aclk); #1;
        axi_bready = 0;
        @(negedge axi_aclk);
        chk("b_done", axi_bvalid, 0);
    endtask

    // mode 0: rready held high; mode 1: rready pattern 1,0,0,1,0,0,...
    task automatic read_data(input [3:0] id, input [7:0] len, input [7:0] d0, input int mode);
        int beat = 0, k = 1, iss = 0, pops = 0, maxout = 0, first_k = 0, last_k = 0;
        while (beat <= int'(len) && k < 200) begin
            axi_rready = (mode == 0) ? 1'b1 : (k % 3 == 1);
            @(negedge axi_aclk);
            if (sram_en && !sram_we) iss++;
            if (axi_rvalid && axi_rready) begin
                pops++;
                chk("r_data", axi_rdata, d0 + 8'(beat));
                chk("r_last", axi_rlast, beat == int'(len));
                chk("r_id", axi_rid, id);
                chk("r_resp", axi_rresp, 2'b00);
                if (beat == 0) first_k = k;
                last_k = k;
                beat++;
            end
            if (iss - pops > maxout) maxout = iss - pops;
            @(posedge axi_aclk); #1;
            k++;
        end
        axi_rready = 0;
        chk("r_complete", beat, int'(len) + 1);
        chk("r_issues", iss, int'(len) + 1);
        chk("r_outstanding_le2", maxout <= 2, 1);
        if (mode == 0) begin
            chk("r_first_latency", first_k, 3);
            chk("r_no_bubbles", last_k - first_k, int'(len));
        end
        @(negedge axi_aclk);
        chk("r_idle_rvalid", axi_rvalid, 0);
    endtask

    initial begin
        repeat (3) @(posedge axi_aclk);
        @(negedge axi_aclk);
        chk("rst_awready", axi_awready, 0);
        chk("rst_arready", axi_arready, 0);
        chk("rst_wready", axi_wready, 0);
        chk("rst_bvalid", axi_bvalid, 0);
        chk("rst_rvalid", axi_rvalid, 0);
        chk("rst_rlast", axi_rlast, 0);
        chk("rst_sram_en", sram_en, 0);
        chk("rst_resp", {axi_bresp, axi_rresp}, 4'h0);
        chk("rst_ids", {axi_bid, axi_rid}, 8'h00);
        chk("rst_rdata", axi_rdata, 8'h00);
        chk("rst_sram_addr", sram_addr, 8'h00);
        chk("rst_sram_wdata", sram_wdata, 8'h00);
        @(posedge axi_aclk); #1;
        axi_areset = 0;

        // Tie on the first cycle after reset: write, then read, then write
        axi_awid = 4'h1; axi_awaddr = 8'h80; axi_awlen = 8'd0; axi_awburst = 2'b01; axi_awvalid = 1;
        axi_arid = 4'h2; axi_araddr = 8'h80; axi_arlen = 8'd0; axi_arburst = 2'b01; axi_arvalid = 1;
        #1;
        chk("tie1_awready", axi_awready, 1);
        chk("tie1_arready", axi_arready, 0);
        @(posedge axi_aclk); #1;
        axi_awvalid = 0;
        write_data(4'h1, 8'h80, 8'd0, 2'b01, 8'h55, 0, 2'b00);
        axi_awid = 4'h3; axi_awaddr = 8'h81; axi_awvalid = 1;
        #1;
        chk("tie2_arready", axi_arready, 1);
        chk("tie2_awready", axi_awready, 0);
        @(posedge axi_aclk); #1;
        axi_arvalid = 0;
        read_data(4'h2, 8'd0, 8'h55, 0);
        axi_arvalid = 1;
        #1;
        chk("tie3_awready", axi_awready, 1);
        chk("tie3_arready", axi_arready, 0);
        @(posedge axi_aclk); #1;
        axi_awvalid = 0; axi_arvalid = 0;
        write_data(4'h3, 8'h81, 8'd0, 2'b01, 8'h66, 0, 2'b00);
        chk("tie_mem81", mem[8'h81], 8'h66);

        // INCR write then read back
        aw_phase(4'h5, 8'h10, 8'd3, 2'b01);
        write_data(4'h5, 8'h10, 8'd3, 2'b01, 8'h01, 3, 2'b00);
        chk("mem13", mem[8'h13], 8'h04);
        ar_phase(4'h6, 8'h10, 8'd3, 2'b01);
        read_data(4'h6, 8'd3, 8'h01, 0);

        // len 7 read under rready backpressure
        aw_phase(4'h7, 8'h40, 8'd7, 2'b01);
        write_data(4'h7, 8'h40, 8'd7, 2'b01, 8'h20, 7, 2'b00);
        ar_phase(4'h8, 8'h40, 8'd7, 2'b01);
        read_data(4'h8, 8'd7, 8'h20, 1);

        // FIXED write to the top address, INCR wrap past 0xFF, bad wlast
        aw_phase(4'h9, 8'hFF, 8'd2, 2'b00);
        write_data(4'h9, 8'hFF, 8'd2, 2'b00, 8'hA0, 2, 2'b00);
        ar_phase(4'h9, 8'hFF, 8'd0, 2'b00);
        read_data(4'h9, 8'd0, 8'hA2, 0);
        aw_phase(4'hB, 8'hFE, 8'd2, 2'b01);
        write_data(4'hB, 8'hFE, 8'd2, 2'b01, 8'hB0, 2, 2'b00);
        chk("wrap_mem00", mem[8'h00], 8'hB2);
        aw_phase(4'hC, 8'h20, 8'd2, 2'b01);
        write_data(4'hC, 8'h20, 8'd2, 2'b01, 8'hD0, 1, 2'b10);

        // Reset while beat 2 of 5 is on the R channel
        ar_phase(4'h4, 8'h40, 8'd4, 2'b01);
        axi_rready = 1;
        @(posedge axi_aclk); #1;
        @(posedge axi_aclk); #1;
        @(posedge axi_aclk); #1;
        @(negedge axi_aclk);
        chk("rst_mid_beat2", {axi_rvalid, axi_rdata}, {1'b1, 8'h21});
        axi_areset = 1;
        @(posedge axi_aclk); #1;
        chk("rst_mid_rvalid", axi_rvalid, 0);
        chk("rst_mid_sram_en", sram_en, 0);
        @(posedge axi_aclk); #1;
        chk("rst_mid_sram_en2", sram_en, 0);
        axi_areset = 0; axi_rready = 0;
        aw_phase(4'hA, 8'h90, 8'd1, 2'b01);
        write_data(4'hA, 8'h90, 8'd1, 2'b01, 8'hC0, 1, 2'b00);
        ar_phase(4'hA, 8'h90, 8'd1, 2'b01);
        read_data(4'hA, 8'd1, 8'hC0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_sram_slave.md
# axi4_sram_slave

AXI4 slave endpoint that terminates the single master port of the many-to-one AXI4 interconnect and converts its bursts into accesses on a single-port synchronous SRAM. It serializes reads and writes with a fair read/write arbiter. It supports INCR and FIXED bursts. A two-entry read buffer sustains one beat per cycle under R-channel backpressure.

## Interface
Parameters:
- IDSIZE, 4: AXI ID width. Must match the interconnect's widened output ID.
- ASIZE, 8: address width. One address equals one DSIZE word.
- LSIZE, 8: burst length field width. Beats = len+1.
- DSIZE, 8: data width.

Ports:
- axi_aclk  in  1  sole clock; all logic on its rising edge
- axi_areset  in  1  synchronous, active-high reset
- axi_awid/awaddr/awlen/awburst  in  IDSIZE/ASIZE/LSIZE/2  write address fields
- axi_awvalid in 1, axi_awready out 1  AW handshake
- axi_wdata/wlast/wvalid  in  DSIZE/1/1  write data; axi_wready out 1
- axi_bid/bresp/bvalid  out  IDSIZE/2/1  write response; axi_bready in 1
- axi_arid/araddr/arlen/arburst  in  IDSIZE/ASIZE/LSIZE/2  read address fields
- axi_arvalid in 1, axi_arready out 1  AR handshake
- axi_rid/rdata/rresp/rlast/rvalid  out  IDSIZE/DSIZE/2/1/1  read data; axi_rready in 1
- sram_en  out  1  SRAM access strobe
- sram_we  out  1  1 = write, 0 = read (valid when sram_en = 1)
- sram_addr  out  ASIZE  word address
- sram_wdata  out  DSIZE  write data
- sram_rdata  in  DSIZE  read data, valid in the cycle after a read strobe

## Operation
- FSM states: IDLE, WR_DATA, WR_RESP, RD_DATA.
- IDLE, arbitration:
  - Only awvalid is high: grant write. Only arvalid is high: grant read.
  - Both are high: grant the opposite of the last served direction. last_dir resets to READ, so write wins the first tie.
  - Grant drives awready or arready combinationally in IDLE only. The handshake latches id, addr, len and burst.
  - Write handshake goes to WR_DATA. Read handshake goes to RD_DATA.
- WR_DATA:
  - wready = 1.
  - Each W handshake drives sram_en = 1, sram_we = 1, sram_addr = cur_addr, sram_wdata = wdata in the same cycle, combinationally.
  - After each beat, cur_addr increments for INCR (burst 2'b01) and WRAP (2'b10, treated as INCR). cur_addr holds for FIXED (2'b00). Addresses wrap modulo 2^ASIZE.
  - The burst ends on beat count = len+1, regardless of wlast.
  - wlast mismatch sets an error flag: wlast = 1 before the final beat, or wlast = 0 on the final beat.
  - On the final beat, go to WR_RESP.
- WR_RESP:
  - bvalid = 1, bid = latched id, bresp = 2'b10 (SLVERR) if the error flag is set, else 2'b00.
  - Outputs hold until bready. Then go to IDLE and set last_dir = WRITE.
- RD_DATA:
  - A read is issued (sram_en = 1, sram_we = 0) when issued_beats < len+1 and fifo_count + inflight < 2.
  - sram_rdata is pushed into the 2-entry FIFO one cycle after each issue, tagged with a last flag.
  - rvalid = FIFO non-empty, rdata = FIFO head, rid = latched id, rresp = 2'b00, rlast = head last flag.
  - Popping the last beat goes to IDLE and sets last_dir = READ.
- sram_en is never asserted outside WR_DATA and RD_DATA. Reads and writes never overlap.

## Timing
- Reset values: awready, wready, bvalid, arready, rvalid, rlast and sram_en are 0. bresp, rresp, bid, rid, rdata, sram_addr and sram_wdata are 0. State is IDLE, the FIFO is empty, last_dir = READ.
- Reset asserted mid-burst abandons the transaction. All outputs take reset values at the next edge, and no further SRAM access occurs.
- Write latency, with AW handshake in cycle 0:
  - wready is high from cycle 1.
  - With continuous wvalid, one SRAM write per cycle.
  - bvalid rises in the cycle after the final W beat.
- Read latency, with AR handshake in cycle 0:
  - First sram_en in cycle 1, sram_rdata in cycle 2.
  - rvalid is high in cycle 3.
  - With rready held high, one beat per cycle and no bubbles.
- Read backpressure:
  - rready low: at most 2 beats are buffered plus in-flight data. Issue stalls and no data is lost.
  - Each rready/rvalid handshake frees one credit. The next issue may occur in that same cycle.
- A new AW or AR is not accepted until the cycle after the B or final-R handshake returns the FSM to IDLE.
- Back-to-back transactions pay a minimum 1-cycle IDLE gap.

## Test plan
- Write INCR, addr 0x10, len 3, data 1,2,3,4 -> SRAM writes at 0x10..0x13. bvalid in the cycle after the 4th beat, bresp 00, bid echoed.
- Read INCR, addr 0x10, len 3 after the above, rready = 1 -> rdata 1,2,3,4 on consecutive cycles starting 3 cycles after the AR handshake. rlast on the 4th beat only.
- Read len 7 with rready toggling 1,0,0,1,… -> all 8 beats in order. At most 2 sram_en reads outstanding beyond pops.
- awvalid and arvalid both high on the first cycle after reset, then both re-asserted -> write served first, then read, then write (alternation).
- FIXED write, addr 0xFF, len 2 -> three writes to 0xFF. INCR write at 0xFE, len 2 -> addresses 0xFE, 0xFF, 0x00. wlast asserted on beat 2 of 3 -> bresp 2'b10.
- Reset asserted during read beat 2 of 5 -> rvalid and sram_en 0 at the next edge. A post-reset write completes normally.
